// File: rtl/ecc_scrubber_if.sv
// ecc_scrubber_if: arbitrated RAM port shared between the scrub engine and the RAM arbiter.
interface ecc_scrubber_if #(
  parameter int ADDRESS_WIDTH = 3
);
  logic                     mem_req;
  logic                     mem_gnt;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [12:0]              mem_wdata;
  logic [12:0]              mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_gnt, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_gnt, mem_rdata);
endinterface

// File: rtl/ecc_scrubber.sv
// ecc_scrubber: sweeps a SECDED RAM, writes back single-bit corrections, logs uncorrectable words.
module ecc_scrubber #(
  parameter int ADDRESS_WIDTH  = 3,
  parameter int READ_LATENCY   = 3,
  parameter int INTERVAL_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [INTERVAL_WIDTH-1:0] interval,
  input  logic                      clr_stats,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                ce_count,
  output logic [7:0]                ue_count,
  output logic                      ue_flag,
  output logic [ADDRESS_WIDTH-1:0]  ue_addr,
  ecc_scrubber_if.master            mem
);
  localparam int LW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX = '1;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT, PAUSE} state_t;
  state_t                    state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d, ue_addr_q, ue_addr_d;
  logic [LW-1:0]             lat_q, lat_d;
  logic [12:0]               rdata_q, rdata_d, wdata_q, wdata_d, fixed;
  logic [INTERVAL_WIDTH-1:0] pause_q, pause_d;
  logic [7:0]                ce_q, ce_d, ue_q, ue_d;
  logic                      ue_flag_q, ue_flag_d, req, par, is_ce, is_ue;
  logic [3:0]                syn, flip;
  // Bit k-1 of the codeword is Hamming position k; position 13 is overall parity.
  assign syn   = {^(rdata_q & 13'h0F80), ^(rdata_q & 13'h0878), ^(rdata_q & 13'h0666), ^(rdata_q & 13'h0555)};
  assign par   = ^rdata_q;
  assign is_ce = par && syn <= 4'd12;
  assign is_ue = syn != 4'd0 && !is_ce;
  assign flip  = syn == 4'd0 ? 4'd12 : syn - 4'd1;
  assign fixed = rdata_q ^ (13'd1 << flip);
  assign req           = state_q == RD_REQ || state_q == WR_REQ;
  assign busy          = state_q != IDLE;
  assign done          = state_q == NEXT && addr_q == ADDR_MAX;
  assign mem.mem_req   = req;
  assign mem.mem_we    = state_q == WR_REQ;
  assign mem.mem_addr  = req ? addr_q : '0;
  assign mem.mem_wdata = wdata_q;
  assign ce_count      = ce_q;
  assign ue_count      = ue_q;
  assign ue_flag       = ue_flag_q;
  assign ue_addr       = ue_addr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      lat_q     <= '0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      pause_q   <= '0;
      ce_q      <= '0;
      ue_q      <= '0;
      ue_flag_q <= 1'b0;
      ue_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      lat_q     <= lat_d;
      rdata_q   <= rdata_d;
      wdata_q   <= wdata_d;
      pause_q   <= pause_d;
      ce_q      <= ce_d;
      ue_q      <= ue_d;
      ue_flag_q <= ue_flag_d;
      ue_addr_q <= ue_addr_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    lat_d     = lat_q;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    pause_d   = pause_q;
    ce_d      = clr_stats ? 8'd0 : ce_q;
    ue_d      = clr_stats ? 8'd0 : ue_q;
    ue_flag_d = clr_stats ? 1'b0 : ue_flag_q;
    ue_addr_d = clr_stats ? '0 : ue_addr_q;
    case (state_q)
      IDLE: begin
        addr_d  = start ? '0 : addr_q;
        state_d = start ? RD_REQ : IDLE;
      end
      RD_REQ: begin
        lat_d   = '0;
        state_d = mem.mem_gnt ? RD_WAIT : RD_REQ;
      end
      RD_WAIT: begin
        if (lat_q == LW'(READ_LATENCY - 1)) begin
          rdata_d = mem.mem_rdata;
          state_d = CHECK;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      CHECK: begin
        // Stats are cleared first so a coincident event still counts once.
        if (is_ce) begin
          ce_d    = ce_d + 8'(ce_d != 8'hFF);
          wdata_d = fixed;
          state_d = WR_REQ;
        end else begin
          if (is_ue) begin
            ue_d      = ue_d + 8'(ue_d != 8'hFF);
            ue_flag_d = 1'b1;
            ue_addr_d = addr_q;
          end
          state_d = NEXT;
        end
      end
      WR_REQ: state_d = mem.mem_gnt ? NEXT : WR_REQ;
      NEXT: begin
        if (addr_q != ADDR_MAX) begin
          addr_d  = addr_q + 1'b1;
          state_d = RD_REQ;
        end else begin
          pause_d = interval;
          state_d = continuous ? PAUSE : IDLE;
        end
      end
      PAUSE: begin
        if (!continuous) begin
          state_d = IDLE;
        end else if (pause_q == '0) begin
          addr_d  = '0;
          state_d = RD_REQ;
        end else begin
          pause_d = pause_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ecc_scrubber.sv
// tb_ecc_scrubber: directed and randomized sweeps against a RAM model with read latency and
// a SECDED reference decoder built from the position/syndrome arithmetic.
module tb_ecc_scrubber;
  localparam int AW = 3, RL = 3, IW = 16, N = 8;
  logic          clk = 0, rst_n = 1, start = 0, continuous = 0, clr_stats = 0, load = 0;
  logic [IW-1:0] interval = '0;
  logic          busy, done, ue_flag;
  logic [7:0]    ce_count, ue_count;
  logic [AW-1:0] ue_addr;
  logic [12:0]   mem [N];
  logic [12:0]   pre [N];
  logic [12:0]   expm [N];
  logic [12:0]   p_d [RL];
  logic [RL-1:0] p_v = '0;
  int            wr_cnt = 0, n_checks = 0, n_fail = 0;
  int            exp_ce = 0, exp_ue = 0, exp_ueaddr = 0, exp_flag = 0;

  ecc_scrubber_if #(.ADDRESS_WIDTH(AW)) mif ();

  ecc_scrubber #(.ADDRESS_WIDTH(AW), .READ_LATENCY(RL), .INTERVAL_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .interval(interval),
    .clr_stats(clr_stats), .busy(busy), .done(done), .ce_count(ce_count), .ue_count(ue_count),
    .ue_flag(ue_flag), .ue_addr(ue_addr), .mem(mif)
  );

  always #5 clk = ~clk;

  // RAM: read data appears only in the cycle before the capture edge, junk otherwise.
  always @(posedge clk) begin
    if (load) begin
      for (int a = 0; a < N; a++) mem[a] <= pre[a];
    end else if (mif.mem_req && mif.mem_gnt && mif.mem_we) begin
      mem[mif.mem_addr] <= mif.mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    p_v    <= {p_v[RL-2:0], mif.mem_req & mif.mem_gnt & ~mif.mem_we};
    p_d[0] <= mem[mif.mem_addr];
    for (int i = 1; i < RL; i++) p_d[i] <= p_d[i-1];
  end
  assign mif.mem_rdata = p_v[RL-1] ? p_d[RL-1] : 13'h1FFF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] w = '0;
    int s = 0;
    int dp [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    for (int i = 0; i < 8; i++) w[dp[i]-1] = d[i];
    for (int k = 1; k <= 12; k++) if (w[k-1]) s ^= k;
    for (int b = 0; b < 4; b++) w[(1 << b) - 1] = s[b];
    w[12] = ^w[11:0];
    return w;
  endfunction

  // 0 clean, 1 correctable (fixed holds the repaired word), 2 uncorrectable
  function automatic int classify(input logic [12:0] w, output logic [12:0] fixed);
    int s = 0;
    int pos;
    for (int k = 1; k <= 12; k++) if (w[k-1]) s ^= k;
    fixed = w;
    if (s == 0 && !(^w)) return 0;
    if ((^w) && s <= 12) begin
      pos = s == 0 ? 13 : s;
      fixed[pos-1] = ~fixed[pos-1];
      return 1;
    end
    return 2;
  endfunction

  task automatic preload();
    load = 1;
    @(negedge clk);
    load = 0;
  endtask

  task automatic clear();
    clr_stats = 1;
    @(negedge clk);
    clr_stats = 0;
    exp_ce = 0; exp_ue = 0; exp_ueaddr = 0; exp_flag = 0;
  endtask

  task automatic predict(output int nce);
    logic [12:0] f;
    int k;
    nce = 0;
    for (int a = 0; a < N; a++) begin
      k = classify(pre[a], f);
      expm[a] = k == 1 ? f : pre[a];
      if (k == 1) begin nce++; exp_ce = exp_ce < 255 ? exp_ce + 1 : 255; end
      if (k == 2) begin exp_ue = exp_ue < 255 ? exp_ue + 1 : 255; exp_flag = 1; exp_ueaddr = a; end
    end
  endtask

  task automatic sweep(input bit rnd, output int n);
    start = 1;
    @(negedge clk);
    start = 0;
    n = 1;
    while (!done && n < 3000) begin
      if (rnd) mif.mem_gnt = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n++;
    end
    mif.mem_gnt = 1;
    check("done_pulse", 32'(done), 1);
  endtask

  task automatic check_results(input int w0, input int nce);
    for (int a = 0; a < N; a++) check($sformatf("mem[%0d]", a), 32'(mem[a]), 32'(expm[a]));
    check("write_count", wr_cnt - w0, nce);
    check("ce_count", 32'(ce_count), exp_ce);
    check("ue_count", 32'(ue_count), exp_ue);
    check("ue_flag", 32'(ue_flag), exp_flag);
    check("ue_addr", 32'(ue_addr), exp_ueaddr);
  endtask

  task automatic run_and_check(input bit rnd);
    int w0, nce, n;
    w0 = wr_cnt;
    predict(nce);
    sweep(rnd, n);
    if (!rnd) check("sweep_cycles", n, N * (RL + 3) + nce);
    check_results(w0, nce);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 0);
    check("done_one_cycle", 32'(done), 0);
  endtask

  task automatic check_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_req", 32'(mif.mem_req), 0);
    check("rst_we", 32'(mif.mem_we), 0);
    check("rst_addr", 32'(mif.mem_addr), 0);
    check("rst_wdata", 32'(mif.mem_wdata), 0);
    check("rst_ce", 32'(ce_count), 0);
    check("rst_ue", 32'(ue_count), 0);
    check("rst_flag", 32'(ue_flag), 0);
    check("rst_ueaddr", 32'(ue_addr), 0);
  endtask

  function automatic logic [12:0] corrupt(input logic [12:0] w, input int flips);
    int p1, p2;
    p1 = $urandom_range(1, 13);
    do p2 = $urandom_range(1, 13); while (p2 == p1);
    if (flips >= 1) w = w ^ (13'd1 << (p1 - 1));
    if (flips >= 2) w = w ^ (13'd1 << (p2 - 1));
    return w;
  endfunction

  initial begin
    int w0, nce, n, k, r;
    mif.mem_gnt = 1;
    for (int a = 0; a < N; a++) pre[a] = encode(8'(a));
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    check_reset();
    preload();
    rst_n = 1;
    @(negedge clk);

    // clean sweep
    run_and_check(0);

    // single-bit error at position 6 of data 0xA5
    pre[5] = 13'hA07;
    preload();
    clear();
    run_and_check(0);
    check("single_fix", 32'(mem[5]), 32'h0A27);
    check("single_ce", 32'(ce_count), 1);

    // overall parity bit error
    for (int a = 0; a < N; a++) pre[a] = encode(8'(a));
    pre[2] = encode(8'd2) ^ 13'h1000;
    preload();
    clear();
    run_and_check(0);

    // double error, then clr_stats
    for (int a = 0; a < N; a++) pre[a] = encode(8'(a));
    pre[6] = encode(8'd6) ^ 13'h000C;
    preload();
    clear();
    run_and_check(0);
    check("dbl_ueaddr", 32'(ue_addr), 6);
    check("dbl_flag", 32'(ue_flag), 1);
    clear();
    check("clr_ce", 32'(ce_count), 0);
    check("clr_ue", 32'(ue_count), 0);
    check("clr_flag", 32'(ue_flag), 0);
    check("clr_ueaddr", 32'(ue_addr), 0);

    // arbitration stall on the read and on the write-back
    for (int a = 0; a < N; a++) pre[a] = encode(8'(a));
    pre[5] = 13'hA07;
    preload();
    clear();
    w0 = wr_cnt;
    predict(nce);
    mif.mem_gnt = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 10; i++) begin
      check("stall_rd_req", 32'(mif.mem_req), 1);
      check("stall_rd_we", 32'(mif.mem_we), 0);
      check("stall_rd_addr", 32'(mif.mem_addr), 0);
      @(negedge clk);
    end
    mif.mem_gnt = 1;
    k = 0;
    while (!(mif.mem_req && mif.mem_we) && k < 500) begin @(negedge clk); k++; end
    check("stall_wr_seen", 32'(mif.mem_req && mif.mem_we), 1);
    mif.mem_gnt = 0;
    for (int i = 0; i < 10; i++) begin
      check("stall_wr_req", 32'(mif.mem_req), 1);
      check("stall_wr_we", 32'(mif.mem_we), 1);
      check("stall_wr_addr", 32'(mif.mem_addr), 5);
      check("stall_wr_data", 32'(mif.mem_wdata), 32'h0A27);
      @(negedge clk);
    end
    mif.mem_gnt = 1;
    k = 0;
    while (!done && k < 500) begin @(negedge clk); k++; end
    check("stall_done", 32'(done), 1);
    check_results(w0, nce);
    @(negedge clk);

    // continuous mode: pause of interval+1 cycles, then reset mid-RD_WAIT
    for (int a = 0; a < N; a++) pre[a] = encode(8'(a));
    preload();
    clear();
    continuous = 1;
    interval = 16'd4;
    predict(nce);
    sweep(0, n);
    check("cont_cycles", n, N * (RL + 3));
    k = 0;
    while (!mif.mem_req && k < 100) begin @(negedge clk); k++; end
    check("cont_gap", k, int'(interval) + 2);
    check("cont_addr0", 32'(mif.mem_addr), 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1 check_reset();
    continuous = 0;
    exp_ce = 0; exp_ue = 0; exp_ueaddr = 0; exp_flag = 0;
    @(negedge clk);
    rst_n = 1;

    // reset during read of a correctable word: no write may follow
    pre[0] = encode(8'd0) ^ 13'h0010;
    preload();
    w0 = wr_cnt;
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    #2 rst_n = 0;
    #1 check("rst2_req", 32'(mif.mem_req), 0);
    check("rst2_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    check("rst_no_write", wr_cnt - w0, 0);
    check("rst_word_kept", 32'(mem[0]), 32'(pre[0]));
    check("rst_idle", 32'(busy), 0);

    // randomized sweeps, alternate random grant
    clear();
    for (int it = 0; it < 40; it++) begin
      for (int a = 0; a < N; a++) begin
        r = $urandom_range(0, 9);
        pre[a] = corrupt(encode(8'($urandom)), r < 2 ? 0 : (r < 8 ? 1 : 2));
      end
      preload();
      run_and_check(it[0]);
    end

    // drive both counters into saturation
    clear();
    for (int it = 0; it < 66; it++) begin
      for (int a = 0; a < N; a++) pre[a] = corrupt(encode(8'($urandom)), a % 2 == 0 ? 1 : 2);
      preload();
      run_and_check(0);
    end
    check("sat_ce", 32'(ce_count), 255);
    check("sat_ue", 32'(ue_count), 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
